// File: rtl/legv8_pkg.sv
// legv8_pkg: LEGv8 operation classes, opcodes, immediate widths and error codes shared by encoder and decoder.
package legv8_pkg;
  typedef enum logic [3:0] {ANDREG, ORRREG, ADDREG, SUBREG, ADDIMM, SUBIMM, MOVZ, B, CBZ, LDUR, STUR} op_e;
  typedef enum logic [1:0] {EMPTY, PEND, FULL} state_e;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam int IMM_ALU_W  = 12;
  localparam int IMM_MOVZ_W = 16;
  localparam int IMM_B_W    = 26;
  localparam int IMM_CBZ_W  = 19;
  localparam int IMM_MEM_W  = 9;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNSUP = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_FULL  = 2'd3;
  function automatic logic fits_u(input logic [31:0] v, input int n);
    return (v >> n) == 32'd0;
  endfunction
  // Signed fit: every bit from the sign position upward must match.
  function automatic logic fits_s(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = 32'($signed(v) >>> (n - 1));
    return t == '0 || t == '1;
  endfunction
endpackage

// File: rtl/legv8_field_pack.sv
// legv8_field_pack: combinational mapping of an operation and its fields to a 32-bit LEGv8 word.
module legv8_field_pack
  import legv8_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  input  logic [1:0]  hw,
  output logic [31:0] word,
  output logic        unsupported,
  output logic        range_err
);
  always_comb begin
    word = '0;
    unsupported = 1'b0;
    range_err = 1'b0;
    case (op)
      ANDREG: word = {OPC_AND, rm, 6'd0, rn, rd};
      ORRREG: word = {OPC_ORR, rm, 6'd0, rn, rd};
      ADDREG: word = {OPC_ADD, rm, 6'd0, rn, rd};
      SUBREG: word = {OPC_SUB, rm, 6'd0, rn, rd};
      ADDIMM: begin word = {OPC_ADDI, imm[11:0], rn, rd}; range_err = !fits_u(imm, IMM_ALU_W); end
      SUBIMM: begin word = {OPC_SUBI, imm[11:0], rn, rd}; range_err = !fits_u(imm, IMM_ALU_W); end
      MOVZ:   begin word = {OPC_MOVZ, hw, imm[15:0], rd}; range_err = !fits_u(imm, IMM_MOVZ_W); end
      B:      begin word = {OPC_B, imm[25:0]}; range_err = !fits_s(imm, IMM_B_W); end
      CBZ:    begin word = {OPC_CBZ, imm[18:0], rd}; range_err = !fits_s(imm, IMM_CBZ_W); end
      LDUR:   begin word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd}; range_err = !fits_s(imm, IMM_MEM_W); end
      STUR:   begin word = {OPC_STUR, imm[8:0], 2'b00, rn, rd}; range_err = !fits_s(imm, IMM_MEM_W); end
      default: unsupported = 1'b1;
    endcase
  end
endmodule

// File: rtl/legv8_insn_encoder.sv
// legv8_insn_encoder: streams symbolic LEGv8 instructions into sequential instruction-memory writes.
module legv8_insn_encoder
  import legv8_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                       CLK,
  input  logic                       resetl,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rn,
  input  logic [4:0]                 in_rm,
  input  logic [31:0]                in_imm,
  input  logic [1:0]                 in_hw,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [31:0]                wr_data,
  output logic                       full,
  output logic                       err_pulse,
  output logic [1:0]                 err_code,
  output logic                       err_sticky,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  if (64'(BASE_ADDR) + 64'(DEPTH) * 64'd4 >= (64'd1 << ADDR_W)) begin : g_addr_chk
    $error("BASE_ADDR + 4*DEPTH does not fit in ADDR_W");
  end
  state_e state;
  logic [31:0] word;
  logic unsupported, range_err, accept, commit, full_rej, good;
  logic [1:0] code;
  legv8_field_pack u_pack (
    .op(in_op), .rd(in_rd), .rn(in_rn), .rm(in_rm), .imm(in_imm), .hw(in_hw),
    .word(word), .unsupported(unsupported), .range_err(range_err)
  );
  assign in_ready = state != PEND || wr_ready;
  assign wr_en = state == PEND;
  assign full = count == CW'(DEPTH);
  assign wr_addr = ADDR_W'(BASE_ADDR + 4 * 32'(count));
  assign accept = in_valid && in_ready && !clear;
  assign commit = wr_en && wr_ready;
  // A word still pending for the last slot already claims it.
  assign full_rej = state == FULL || (state == PEND && count == CW'(DEPTH - 1));
  assign code = unsupported ? ERR_UNSUP : full_rej ? ERR_FULL : range_err ? ERR_RANGE : ERR_NONE;
  assign good = accept && code == ERR_NONE;
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= EMPTY;
      wr_data <= '0;
      err_pulse <= 1'b0;
      err_code <= ERR_NONE;
      err_sticky <= 1'b0;
      count <= '0;
    end else if (clear) begin
      state <= EMPTY;
      err_pulse <= 1'b0;
      err_code <= ERR_NONE;
      err_sticky <= 1'b0;
      count <= '0;
    end else begin
      err_pulse <= accept && !good;
      err_code <= accept ? code : ERR_NONE;
      err_sticky <= err_sticky || (accept && !good);
      count <= count + CW'(commit);
      if (good) wr_data <= word;
      state <= good ? PEND : commit ? (count == CW'(DEPTH - 1) ? FULL : EMPTY) : state;
    end
  end
endmodule

// File: tb/tb_legv8_insn_encoder.sv
// tb_legv8_insn_encoder: directed checks of encoding, handshake, errors, full/clear and async reset.
module tb_legv8_insn_encoder;
  import legv8_pkg::*;
  logic CLK = 0, resetl = 0, clear = 0, in_valid = 0, in_ready, wr_en, wr_ready = 1;
  logic [3:0] in_op = 0;
  logic [4:0] in_rd = 0, in_rn = 0, in_rm = 0;
  logic [31:0] in_imm = 0, wr_data;
  logic [1:0] in_hw = 0, err_code;
  logic [15:0] wr_addr;
  logic full, err_pulse, err_sticky;
  logic [2:0] count;
  int checks = 0, errors = 0;

  legv8_insn_encoder #(.BASE_ADDR(0), .DEPTH(4), .ADDR_W(16)) dut (
    .CLK(CLK), .resetl(resetl), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_hw(in_hw),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .full(full),
    .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky), .count(count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  localparam int NV = 17;
  logic [3:0]  v_op   [NV] = '{4'(ANDREG), 4'(ORRREG), 4'(SUBREG), 4'(ADDIMM), 4'(SUBIMM), 4'(SUBIMM), 4'(MOVZ), 4'(MOVZ),
                               4'(B), 4'(B), 4'(B), 4'(CBZ), 4'(CBZ), 4'(STUR), 4'(LDUR), 4'd11, 4'd15};
  logic [4:0]  v_rd   [NV] = '{1, 1, 31, 0, 2, 0, 0, 7, 0, 0, 0, 5, 5, 1, 0, 0, 0};
  logic [4:0]  v_rn   [NV] = '{2, 2, 31, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0};
  logic [4:0]  v_rm   [NV] = '{3, 3, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] v_imm  [NV] = '{0, 0, 123, 4095, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h01FFFFFF, 32'h02000000,
                               32'hFE000000, 32'hFFFC0000, 32'h00040000, 32'hFFFFFF00, 256, 0, 32'h7FFFFFFF};
  logic [1:0]  v_hw   [NV] = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] v_data [NV] = '{32'h8A030041, 32'hAA030041, 32'hCB1F03FF, 32'h913FFC00, 32'hD1000462, 0, 0, 32'hD2E24687,
                               32'h15FFFFFF, 0, 32'h16000000, 32'hB4800005, 0, 32'hF8100041, 0, 0, 0};
  logic [1:0]  v_err  [NV] = '{0, 0, 0, 0, 0, 2, 2, 0, 0, 2, 0, 0, 2, 0, 2, 1, 1};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, rn, rm, input logic [31:0] imm, input logic [1:0] hw);
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_hw = hw; in_valid = 1;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, rn, rm, input logic [31:0] imm, input logic [1:0] hw);
    drive(op, rd, rn, rm, imm, hw);
    step();
    in_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, full, err_pulse, err_code, err_sticky, count} !== {1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b en=%b a=%h d=%h f=%b ep=%b ec=%0d es=%b c=%0d", in_ready, wr_en, wr_addr, wr_data, full, err_pulse, err_code, err_sticky, count);
    end
    resetl = 1;
    step();
  endtask

  task automatic test_add();
    wr_ready = 1;
    send(4'(ADDREG), 1, 2, 3, 0, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 16'h0, 32'h8B030041, 3'd0}) begin
      errors++; $display("FAIL add_write got en=%b a=%h d=%h c=%0d exp 1 0000 8b030041 0", wr_en, wr_addr, wr_data, count);
    end
    step();
    checks++;
    if ({wr_en, count} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL add_commit got en=%b c=%0d exp 0 1", wr_en, count);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    drive(4'(LDUR), 9, 10, 0, 32'hFFFFFFF8, 0);
    step();
    drive(4'(B), 0, 0, 0, 32'hFFFFFFFF, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b1, 16'h0, 32'hF85F8149, 1'b1}) begin
      errors++; $display("FAIL b2b_first got en=%b a=%h d=%h rdy=%b exp 1 0000 f85f8149 1", wr_en, wr_addr, wr_data, in_ready);
    end
    step();
    in_valid = 0;
    checks++;
    if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 16'h4, 32'h17FFFFFF, 3'd1}) begin
      errors++; $display("FAIL b2b_second got en=%b a=%h d=%h c=%0d exp 1 0004 17ffffff 1", wr_en, wr_addr, wr_data, count);
    end
    step();
    checks++;
    if ({wr_en, count} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL b2b_commit got en=%b c=%0d exp 0 2", wr_en, count);
    end
  endtask

  task automatic test_range();
    do_clear();
    send(4'(ADDIMM), 0, 0, 0, 4096, 0);
    checks++;
    if ({err_pulse, err_code, err_sticky, wr_en, count} !== {1'b1, 2'd2, 1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL range_reject got ep=%b ec=%0d es=%b en=%b c=%0d exp 1 2 1 0 0", err_pulse, err_code, err_sticky, wr_en, count);
    end
    send(4'(MOVZ), 0, 0, 0, 32'h0000FFFF, 1);
    checks++;
    if ({err_pulse, err_sticky, wr_en, wr_addr, wr_data} !== {1'b0, 1'b1, 1'b1, 16'h0, 32'hD2BFFFE0}) begin
      errors++; $display("FAIL range_next got ep=%b es=%b en=%b a=%h d=%h exp 0 1 1 0000 d2bfffe0", err_pulse, err_sticky, wr_en, wr_addr, wr_data);
    end
    step();
  endtask

  task automatic test_vectors();
    for (int i = 0; i < NV; i++) begin
      do_clear();
      send(v_op[i], v_rd[i], v_rn[i], v_rm[i], v_imm[i], v_hw[i]);
      checks++;
      if ({err_pulse, err_code, wr_en} !== {v_err[i] != 0, v_err[i], v_err[i] == 0}) begin
        errors++; $display("FAIL vec%0d_status got ep=%b ec=%0d en=%b exp ec=%0d", i, err_pulse, err_code, wr_en, v_err[i]);
      end
      if (v_err[i] == 0) begin
        checks++;
        if (wr_data !== v_data[i]) begin
          errors++; $display("FAIL vec%0d_data got %h exp %h", i, wr_data, v_data[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_stall();
    do_clear();
    wr_ready = 0;
    send(4'(ADDREG), 1, 2, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wr_en, wr_addr, wr_data, in_ready, count} !== {1'b1, 16'h0, 32'h8B030041, 1'b0, 3'd0}) begin
        errors++; $display("FAIL stall%0d got en=%b a=%h d=%h rdy=%b c=%0d", i, wr_en, wr_addr, wr_data, in_ready, count);
      end
      step();
    end
    wr_ready = 1;
    step();
    checks++;
    if ({wr_en, count} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL stall_commit got en=%b c=%0d exp 0 1", wr_en, count);
    end
  endtask

  task automatic test_full();
    do_clear();
    wr_ready = 1;
    drive(4'(ADDREG), 1, 2, 3, 0, 0);
    for (int i = 0; i < 5; i++) step();
    in_valid = 0;
    checks++;
    if ({full, count, err_pulse, err_code, wr_en, wr_addr, in_ready} !== {1'b1, 3'd4, 1'b1, 2'd3, 1'b0, 16'h10, 1'b1}) begin
      errors++; $display("FAIL full_fifth got f=%b c=%0d ep=%b ec=%0d en=%b a=%h rdy=%b", full, count, err_pulse, err_code, wr_en, wr_addr, in_ready);
    end
    send(4'(ADDIMM), 0, 0, 0, 4096, 0);
    checks++;
    if ({err_pulse, err_code, count} !== {1'b1, 2'd3, 3'd4}) begin
      errors++; $display("FAIL full_over_range got ep=%b ec=%0d c=%0d exp 1 3 4", err_pulse, err_code, count);
    end
    send(4'd12, 0, 0, 0, 0, 0);
    checks++;
    if ({err_pulse, err_code} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL unsup_over_full got ep=%b ec=%0d exp 1 1", err_pulse, err_code);
    end
    do_clear();
    checks++;
    if ({count, full, wr_addr, err_sticky} !== {3'd0, 1'b0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL clear got c=%0d f=%b a=%h es=%b exp 0 0 0000 0", count, full, wr_addr, err_sticky);
    end
    send(4'(ORRREG), 1, 2, 3, 0, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0, 32'hAA030041}) begin
      errors++; $display("FAIL clear_next got en=%b a=%h d=%h exp 1 0000 aa030041", wr_en, wr_addr, wr_data);
    end
    step();
  endtask

  task automatic test_async_reset();
    do_clear();
    send(4'd13, 0, 0, 0, 0, 0);
    wr_ready = 0;
    send(4'(ADDREG), 1, 2, 3, 0, 0);
    #2 resetl = 0;
    #1;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, full, err_pulse, err_code, err_sticky, count} !== {1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL async_reset got rdy=%b en=%b a=%h d=%h es=%b c=%0d", in_ready, wr_en, wr_addr, wr_data, err_sticky, count);
    end
    step();
    resetl = 1;
    wr_ready = 1;
    step();
    send(4'(ADDREG), 1, 2, 3, 0, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0, 32'h8B030041}) begin
      errors++; $display("FAIL post_reset_write got en=%b a=%h d=%h", wr_en, wr_addr, wr_data);
    end
    step();
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("FAIL post_reset_count got %0d exp 1", count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_range();
    test_vectors();
    test_stall();
    test_full();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/legv8_insn_encoder.md
# legv8_insn_encoder

Streaming LEGv8 instruction encoder: accepts symbolic instructions (operation class plus register and immediate fields) over a valid/ready handshake and emits 32-bit machine words as sequential writes into instruction memory. It is the producer-side counterpart of the single-cycle control decoder: every word it writes decodes there to the same operation class. It sits between the testbench or boot loader and instruction memory, and loads programs before the CPU is released from reset.

## Interface
- BASE_ADDR, 0: byte address of the first written word.
- DEPTH, 64: maximum words per program (counter range 0..DEPTH).
- ADDR_W, 16: width of wr_addr.
- CLK  in  1  single clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- clear  in  1  synchronous pulse: empty the pipeline, count:=0, err_sticky:=0; overrides all other inputs that cycle.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept this cycle.
- in_op  in  4  operation class (legv8_pkg::op_e).
- in_rd, in_rn, in_rm  in  5 each  Rd/Rt, Rn, Rm.
- in_imm  in  32  immediate, two's complement.
- in_hw  in  2  MOVZ shift selector.
- wr_en  out  1  write request to instruction memory.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  ADDR_W  BASE_ADDR + 4*count.
- wr_data  out  32  encoded word.
- full  out  1  count == DEPTH.
- err_pulse  out  1  one cycle: the request was rejected.
- err_code  out  2  1=unsupported op, 2=immediate out of range, 3=write while full; valid with err_pulse.
- err_sticky  out  1  set by any err_pulse; cleared by clear or reset.
- count  out  $clog2(DEPTH+1)  words committed.

## Operation
- Encoding, with bits [31:21] as the opcode field:
  - AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000: Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
  - ADDI 1001000100, SUBI 1101000100: [31:22], imm12 unsigned [21:10].
  - MOVZ 110100101: [31:23], hw[22:21], imm16 unsigned [20:5].
  - B 000101: [31:26], imm26 signed [25:0].
  - CBZ 10110100: [31:24], imm19 signed [23:5], Rt[4:0].
  - LDUR 11111000010, STUR 11111000000: imm9 signed [20:12], [11:10]=00, Rn, Rt.
- Range check: unsigned fields require 0 <= imm < 2^n; signed fields require -2^(n-1) <= imm < 2^(n-1). Register-form ops ignore in_imm.
- Rejection is decided at acceptance, in priority order: unsupported in_op, then full, then range. A rejected request is consumed (handshake completes), produces no write and leaves count unchanged.
- FSM states:
  - EMPTY: no pending write.
  - PEND: wr_en=1 and the word is held.
  - FULL: count == DEPTH.
- Transitions:
  - EMPTY→PEND on a valid accept.
  - PEND→EMPTY on wr_ready with no new accept.
  - PEND→PEND on wr_ready and an accept in the same cycle (back-to-back).
  - PEND→FULL when the committing write makes count == DEPTH.
  - FULL→EMPTY on clear.
- In FULL, requests are still accepted but rejected with err_code=3.
- count increments on wr_en && wr_ready.

## Timing
- Reset values: in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, full=0, err_pulse=0, err_code=0, err_sticky=0, count=0, state EMPTY.
- in_ready = (state!=PEND) || wr_ready (combinational from wr_ready). No combinational path from in_* to wr_*.
- Latency: accept in cycle N → wr_en, wr_addr, wr_data valid from cycle N+1. err_pulse is asserted in N+1.
- While wr_en=1 && wr_ready=0, wr_addr and wr_data are held stable.
- Throughput: 1 word/cycle with wr_ready held high.
- clear in the same cycle as a pending write: the write is dropped and count:=0.
- Asynchronous reset mid-write: wr_en drops immediately and the write is lost.
- wr_addr uses ADDR_W-bit arithmetic. BASE_ADDR + 4*DEPTH must fit in ADDR_W; this is checked by an elaboration assertion.

## Structure
- legv8_pkg holds: op_e enum (ANDREG, ORRREG, ADDREG, SUBREG, ADDIMM, SUBIMM, MOVZ, B, CBZ, LDUR, STUR), per-op opcode constants, immediate widths, and the err_code constants. The control decoder imports the same package.
- Sub-module legv8_field_pack is purely combinational and maps (op, fields) to {word, unsupported, range_err}. The top level holds the FSM, output register and counter.

## Test plan
- ADDREG rd=1 rn=2 rm=3, wr_ready=1 → one cycle later wr_en=1, wr_addr=0x0000, wr_data=0x8B030041; count=1.
- LDUR rt=9 rn=10 imm=-8, then B imm=-1, back-to-back → wr_data 0xF85F8149 @0x0000, then 0x17FFFFFF @0x0004 on consecutive cycles.
- ADDIMM imm=4096 → err_pulse=1, err_code=2, err_sticky=1, wr_en=0, count unchanged. The next MOVZ rd=0 imm=0xFFFF hw=1 is written to the same address as 0xD2BFFFE0.
- wr_ready low for 3 cycles during PEND → wr_en, wr_addr and wr_data stable; in_ready=0; then one commit.
- DEPTH=4: stream 5 valid ops → full=1 after the 4th commit, and the 5th gives err_code=3. clear → count=0, full=0, and the next write lands at BASE_ADDR.
- resetl deasserted during a stalled PEND → all outputs take their reset values asynchronously. After release, the first write goes to BASE_ADDR.
